// File: rtl/vga_pkg.sv
// Shared VGA capture types: default active geometry, capture state encoding
// and the 24-bit pixel layout also used by the timing generator.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef enum logic [1:0] {
      SEARCH      = 2'd0,
      WAIT_ACTIVE = 2'd1,
      CAPTURE     = 2'd2,
      WAIT_VSYNC  = 2'd3
   } cap_state_t;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } pixel_t;

   localparam pixel_t PIXEL_IDLE = '{red: 8'd0, green: 8'd0, blue: 8'd0};

   function automatic pixel_t make_pixel(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
      pixel_t p;
      p.red   = r;
      p.green = g;
      p.blue  = b;
      return p;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input staging for the capture block: every video input is registered once
// (s1); the sync and blank lines get a second stage (s2) so edges can be
// derived as s2/s1 pairs.
module vga_sync_edge
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank_n,
   input  logic        fifo_full,
   input  logic [23:0] pixel,
   output logic        blank_s1,
   output logic        full_s1,
   output logic [23:0] pixel_s1,
   output logic        hsync_fall,
   output logic        hsync_rise,
   output logic        vsync_fall,
   output logic        vsync_rise,
   output logic        blank_fall,
   output logic        blank_rise
);

   logic   hsync_s1_r;
   logic   hsync_s2_r;
   logic   vsync_s1_r;
   logic   vsync_s2_r;
   logic   blank_s1_r;
   logic   blank_s2_r;
   logic   full_s1_r;
   pixel_t pixel_s1_r;

   // Two-stage input pipeline; reset parks it at the idle level (syncs high, blanked, black)
   always_ff @(posedge clk) begin
      if (rst) begin
         hsync_s1_r <= 1'b1;
         hsync_s2_r <= 1'b1;
         vsync_s1_r <= 1'b1;
         vsync_s2_r <= 1'b1;
         blank_s1_r <= 1'b0;
         blank_s2_r <= 1'b0;
         full_s1_r  <= 1'b0;
         pixel_s1_r <= PIXEL_IDLE;
      end else begin
         hsync_s1_r <= hsync;
         hsync_s2_r <= hsync_s1_r;
         vsync_s1_r <= vsync;
         vsync_s2_r <= vsync_s1_r;
         blank_s1_r <= blank_n;
         blank_s2_r <= blank_s1_r;
         full_s1_r  <= fifo_full;
         pixel_s1_r <= pixel;
      end
   end

   assign blank_s1   = blank_s1_r;
   assign full_s1    = full_s1_r;
   assign pixel_s1   = pixel_s1_r;
   assign hsync_fall = hsync_s2_r & ~hsync_s1_r;
   assign hsync_rise = ~hsync_s2_r & hsync_s1_r;
   assign vsync_fall = vsync_s2_r & ~vsync_s1_r;
   assign vsync_rise = ~vsync_s2_r & vsync_s1_r;
   assign blank_fall = blank_s2_r & ~blank_s1_r;
   assign blank_rise = ~blank_s2_r & blank_s1_r;

endmodule

// File: rtl/vga_capture.sv
// VGA frame capture: locks onto vsync, writes each active pixel into a
// downstream FIFO in raster order and tracks line/frame/overflow errors.
module vga_capture
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank_n,
   input  logic [7:0]  red,
   input  logic [7:0]  green,
   input  logic [7:0]  blue,
   input  logic        fifo_full,
   input  logic        clear_err,
   output logic        fifo_wreq,
   output logic [23:0] fifo_wdata,
   output logic        frame_start,
   output logic        frame_done,
   output logic        locked,
   output logic        overflow,
   output logic        line_err,
   output logic        frame_err
);

   localparam logic [9:0] H_LIM = H_ACTIVE[9:0];
   localparam logic [9:0] V_LIM = V_ACTIVE[9:0];

   pixel_t     pixel_in_s;
   pixel_t     pixel_s1_s;
   logic       blank_s1_s;
   logic       full_s1_s;
   logic       hsync_fall_s;
   logic       hsync_rise_s;
   logic       vsync_fall_s;
   logic       vsync_rise_s;
   logic       blank_fall_s;
   logic       blank_rise_s;
   logic       unused_edges_s;

   cap_state_t state_r;
   cap_state_t state_nxt_s;
   logic [9:0] x_r;
   logic [9:0] x_nxt_s;
   logic [9:0] y_r;
   logic [9:0] y_nxt_s;
   logic [9:0] y_inc_s;
   logic       take_s;
   logic       start_s;
   logic       frame_end_s;
   logic       restart_s;
   logic       line_set_s;
   logic       frame_set_s;
   logic       ovf_set_s;
   logic       write_s;
   logic       err_any_s;
   logic       locked_nxt_s;
   logic       frame_bad_nxt_s;

   logic       fifo_wreq_r;
   pixel_t     wdata_r;
   logic       frame_start_r;
   logic       frame_done_r;
   logic       locked_r;
   logic       frame_bad_r;
   logic       overflow_r;
   logic       line_err_r;
   logic       frame_err_r;

   assign pixel_in_s = make_pixel(red, green, blue);

   vga_sync_edge u_sync_edge (
      .clk        (clk),
      .rst        (rst),
      .hsync      (hsync),
      .vsync      (vsync),
      .blank_n    (blank_n),
      .fifo_full  (fifo_full),
      .pixel      (pixel_in_s),
      .blank_s1   (blank_s1_s),
      .full_s1    (full_s1_s),
      .pixel_s1   (pixel_s1_s),
      .hsync_fall (hsync_fall_s),
      .hsync_rise (hsync_rise_s),
      .vsync_fall (vsync_fall_s),
      .vsync_rise (vsync_rise_s),
      .blank_fall (blank_fall_s),
      .blank_rise (blank_rise_s)
   );

   // Horizontal sync and the rising edges carry no capture decision here
   assign unused_edges_s = ^{hsync_fall_s, hsync_rise_s, vsync_rise_s, blank_rise_s};

   assign y_inc_s   = y_r + 10'd1;
   assign ovf_set_s = take_s & full_s1_s;
   assign write_s   = take_s & ~full_s1_s;
   assign err_any_s = ovf_set_s | line_set_s | frame_set_s;

   // Next-state and per-pixel decisions from the s1 stage and s2/s1 edges
   always_comb begin
      state_nxt_s = state_r;
      x_nxt_s     = x_r;
      y_nxt_s     = y_r;
      take_s      = 1'b0;
      start_s     = 1'b0;
      frame_end_s = 1'b0;
      restart_s   = 1'b0;
      line_set_s  = 1'b0;
      frame_set_s = 1'b0;
      if (!en) begin
         state_nxt_s = SEARCH;
         x_nxt_s     = 10'd0;
         y_nxt_s     = 10'd0;
      end else if (vsync_fall_s) begin
         restart_s   = 1'b1;
         frame_set_s = (state_r == CAPTURE) && (y_r < V_LIM);
         state_nxt_s = WAIT_ACTIVE;
         x_nxt_s     = 10'd0;
         y_nxt_s     = 10'd0;
      end else begin
         case (state_r)
            SEARCH: begin
               state_nxt_s = SEARCH;
            end
            WAIT_ACTIVE: begin
               if (blank_s1_s) begin
                  take_s      = 1'b1;
                  start_s     = 1'b1;
                  x_nxt_s     = x_r + 10'd1;
                  state_nxt_s = CAPTURE;
               end else begin
                  state_nxt_s = WAIT_ACTIVE;
               end
            end
            CAPTURE: begin
               if (blank_s1_s) begin
                  if (x_r < H_LIM) begin
                     take_s  = 1'b1;
                     x_nxt_s = x_r + 10'd1;
                  end else begin
                     line_set_s = 1'b1;
                  end
               end else if (blank_fall_s) begin
                  line_set_s = (x_r != H_LIM);
                  x_nxt_s    = 10'd0;
                  y_nxt_s    = y_inc_s;
                  if (y_inc_s == V_LIM) begin
                     frame_end_s = 1'b1;
                     state_nxt_s = WAIT_VSYNC;
                  end else begin
                     state_nxt_s = CAPTURE;
                  end
               end else begin
                  state_nxt_s = CAPTURE;
               end
            end
            WAIT_VSYNC: begin
               frame_set_s = blank_s1_s;
               state_nxt_s = WAIT_VSYNC;
            end
            default: begin
               state_nxt_s = SEARCH;
            end
         endcase
      end
   end

   // Lock tracking: any error drops lock at once; a clean frame end regains it
   always_comb begin
      locked_nxt_s    = locked_r;
      frame_bad_nxt_s = frame_bad_r;
      if (!en || err_any_s) begin
         locked_nxt_s = 1'b0;
      end else if (frame_end_s) begin
         locked_nxt_s = ~frame_bad_r;
      end else begin
         locked_nxt_s = locked_r;
      end
      if (restart_s) begin
         frame_bad_nxt_s = 1'b0;
      end else begin
         frame_bad_nxt_s = frame_bad_r | err_any_s;
      end
   end

   // State, counters and registered outputs; sticky flags keep a new error over clear_err
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= SEARCH;
         x_r           <= 10'd0;
         y_r           <= 10'd0;
         fifo_wreq_r   <= 1'b0;
         wdata_r       <= PIXEL_IDLE;
         frame_start_r <= 1'b0;
         frame_done_r  <= 1'b0;
         locked_r      <= 1'b0;
         frame_bad_r   <= 1'b0;
         overflow_r    <= 1'b0;
         line_err_r    <= 1'b0;
         frame_err_r   <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         x_r           <= x_nxt_s;
         y_r           <= y_nxt_s;
         fifo_wreq_r   <= write_s;
         if (write_s) begin
            wdata_r <= pixel_s1_s;
         end else begin
            wdata_r <= wdata_r;
         end
         frame_start_r <= start_s;
         frame_done_r  <= frame_end_s;
         locked_r      <= locked_nxt_s;
         frame_bad_r   <= frame_bad_nxt_s;
         overflow_r    <= (overflow_r & ~clear_err) | ovf_set_s;
         line_err_r    <= (line_err_r & ~clear_err) | line_set_s;
         frame_err_r   <= (frame_err_r & ~clear_err) | frame_set_s;
      end
   end

   assign fifo_wreq   = fifo_wreq_r;
   assign fifo_wdata  = wdata_r;
   assign frame_start = frame_start_r;
   assign frame_done  = frame_done_r;
   assign locked      = locked_r;
   assign overflow    = overflow_r;
   assign line_err    = line_err_r;
   assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a reduced 16x8 active raster.
// A frame-level model (pixel column/row counters plus "synced / started /
// complete" frame progress) predicts every output each cycle; directed frames
// pin the model with hand-counted write totals and flag values.
`timescale 1ns/1ps
module tb_vga_capture;

   localparam int H = 16;
   localparam int V = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b1;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic        blank_n = 1'b0;
   logic [7:0]  red = 8'd0;
   logic [7:0]  green = 8'd0;
   logic [7:0]  blue = 8'd0;
   logic        fifo_full = 1'b0;
   logic        clear_err = 1'b0;
   logic        fifo_wreq;
   logic [23:0] fifo_wdata;
   logic        frame_start;
   logic        frame_done;
   logic        locked;
   logic        overflow;
   logic        line_err;
   logic        frame_err;

   vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank_n     (blank_n),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .fifo_full   (fifo_full),
      .clear_err   (clear_err),
      .fifo_wreq   (fifo_wreq),
      .fifo_wdata  (fifo_wdata),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .locked      (locked),
      .overflow    (overflow),
      .line_err    (line_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;
   int n_prints = 0;
   int wr_cnt = 0;
   int fs_cnt = 0;
   int fd_cnt = 0;

   // stimulus knobs
   int full_pct = 0;
   int clr_rate = 0;
   int endrop = 0;
   int rst_rate = 0;
   bit en_base = 1'b1;
   bit force_full = 1'b0;
   bit want_rst = 1'b1;
   bit clr_req = 1'b0;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        vs;
      logic        bn;
      logic        full;
      logic [23:0] pix;
   } samp_t;
   localparam samp_t IDLE = {1'b1, 1'b0, 1'b0, 24'd0};

   samp_t cur = IDLE;   // what the DUT registered last edge
   samp_t prv = IDLE;   // the edge before that
   bit synced = 1'b0, started = 1'b0, complete = 1'b0, bad = 1'b0;
   int col = 0, row = 0;
   logic e_wreq = 1'b0, e_fs = 1'b0, e_fd = 1'b0, e_locked = 1'b0;
   logic e_ovf = 1'b0, e_le = 1'b0, e_fe = 1'b0;
   logic [23:0] e_wdata = 24'd0;

   task automatic model_step();
      bit ov, le, fe, fend, restart;
      ov = 1'b0; le = 1'b0; fe = 1'b0; fend = 1'b0; restart = 1'b0;
      e_wreq = 1'b0; e_fs = 1'b0; e_fd = 1'b0;
      if (rst) begin
         synced = 1'b0; started = 1'b0; complete = 1'b0; bad = 1'b0;
         col = 0; row = 0;
         e_wdata = 24'd0; e_locked = 1'b0;
         e_ovf = 1'b0; e_le = 1'b0; e_fe = 1'b0;
         cur = IDLE; prv = IDLE;
      end else begin
         if (!en) begin
            synced = 1'b0; started = 1'b0; complete = 1'b0;
            col = 0; row = 0;
         end else if (prv.vs && !cur.vs) begin
            if (started && !complete) fe = 1'b1;
            restart = 1'b1;
            synced = 1'b1; started = 1'b0; complete = 1'b0;
            col = 0; row = 0;
         end else if (synced && !complete && cur.bn) begin
            if (!started) begin
               started = 1'b1;
               e_fs = 1'b1;
            end
            if (col < H) begin
               if (cur.full) ov = 1'b1;
               else begin
                  e_wreq = 1'b1;
                  e_wdata = cur.pix;
               end
               col++;
            end else le = 1'b1;
         end else if (synced && started && !complete && prv.bn && !cur.bn) begin
            if (col != H) le = 1'b1;
            col = 0;
            row++;
            if (row == V) begin
               complete = 1'b1;
               e_fd = 1'b1;
               fend = 1'b1;
            end
         end else if (complete && cur.bn) begin
            fe = 1'b1;
         end
         if (!en || ov || le || fe) e_locked = 1'b0;
         else if (fend) e_locked = !bad;
         if (restart) bad = 1'b0;
         else bad = bad | ov | le | fe;
         e_ovf = (e_ovf & !clear_err) | ov;
         e_le  = (e_le & !clear_err) | le;
         e_fe  = (e_fe & !clear_err) | fe;
         prv = cur;
         cur = {vsync, blank_n, fifo_full, red, green, blue};
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // per-cycle comparison against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         n_checks++;
         if ({fifo_wreq, fifo_wdata, frame_start, frame_done, locked, overflow, line_err, frame_err} !==
             {e_wreq, e_wdata, e_fs, e_fd, e_locked, e_ovf, e_le, e_fe}) begin
            n_err++;
            if (n_prints < 20) begin
               n_prints++;
               $display("FAIL outputs @%0t got wreq=%b wdata=%h fs=%b fd=%b lk=%b ov=%b le=%b fe=%b required wreq=%b wdata=%h fs=%b fd=%b lk=%b ov=%b le=%b fe=%b",
                        $time, fifo_wreq, fifo_wdata, frame_start, frame_done, locked, overflow, line_err, frame_err,
                        e_wreq, e_wdata, e_fs, e_fd, e_locked, e_ovf, e_le, e_fe);
            end
         end
         if (fifo_wreq === 1'b1) wr_cnt++;
         if (frame_start === 1'b1) fs_cnt++;
         if (frame_done === 1'b1) fd_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic hs, input logic vs, input logic bn);
      @(negedge clk);
      hsync = hs;
      vsync = vs;
      blank_n = bn;
      red = 8'($urandom);
      green = 8'($urandom);
      blue = 8'($urandom);
      fifo_full = force_full || ($urandom_range(99, 0) < full_pct);
      clear_err = clr_req || ($urandom_range(999, 0) < clr_rate);
      en = en_base && !($urandom_range(999, 0) < endrop);
      rst = want_rst || ($urandom_range(9999, 0) < rst_rate);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
   endtask

   task automatic pulse_clear();
      clr_req = 1'b1;
      idle(1);
      clr_req = 1'b0;
      idle(2);
   endtask

   task automatic zero_counts();
      wr_cnt = 0;
      fs_cnt = 0;
      fd_cnt = 0;
   endtask

   // 2 vsync lines, 2 back-porch lines, V active lines, 1 front-porch line
   task automatic gen_frame(input int long_row, input int short_row, input int stop_rows,
                            input int full_row, input int full_col,
                            input int rst_row, input int rst_col);
      for (int ln = 0; ln < V + 5; ln++) begin
         int ar;
         bit act;
         int npix;
         ar = ln - 4;
         act = (ar >= 0) && (ar < V);
         if (act && ar >= stop_rows) begin
            force_full = 1'b0;
            want_rst = 1'b0;
            return;
         end
         npix = act ? (H + ((ar == long_row) ? 1 : 0) - ((ar == short_row) ? 1 : 0)) : 0;
         for (int c = 0; c < npix + 6; c++) begin
            force_full = act && (ar == full_row) && (c >= full_col) && (c < full_col + 3);
            want_rst = act && (ar == rst_row) && (c >= rst_col) && (c < rst_col + 2);
            cyc((c >= npix + 2 && c < npix + 4) ? 1'b0 : 1'b1, (ln < 2) ? 1'b0 : 1'b1, (c < npix) ? 1'b1 : 1'b0);
         end
      end
      force_full = 1'b0;
      want_rst = 1'b0;
   endtask

   task automatic clean_frame();
      gen_frame(-1, -1, V, -1, -1, -1, -1);
   endtask

   initial begin
      // reset
      idle(3);
      chk("rst_wreq", fifo_wreq, 0);
      chk("rst_wdata", fifo_wdata, 0);
      chk("rst_locked", locked, 0);
      chk("rst_flags", {overflow, line_err, frame_err}, 0);
      want_rst = 1'b0;
      idle(4);

      // clean frame
      zero_counts();
      clean_frame();
      idle(4);
      chk("clean_writes", wr_cnt, H * V);
      chk("clean_frame_start", fs_cnt, 1);
      chk("clean_frame_done", fd_cnt, 1);
      chk("clean_locked", locked, 1);
      chk("clean_flags", {overflow, line_err, frame_err}, 0);

      // three-cycle FIFO full at pixel (5,3)
      zero_counts();
      gen_frame(-1, -1, V, 3, 5, -1, -1);
      idle(4);
      chk("ovf_writes", wr_cnt, H * V - 3);
      chk("ovf_flag", overflow, 1);
      chk("ovf_line_err", line_err, 0);
      chk("ovf_locked", locked, 0);
      pulse_clear();
      chk("ovf_cleared", overflow, 0);

      // row 5 one pixel too long
      zero_counts();
      gen_frame(5, -1, V, -1, -1, -1, -1);
      idle(4);
      chk("long_writes", wr_cnt, H * V);
      chk("long_line_err", line_err, 1);
      chk("long_locked", locked, 0);
      pulse_clear();
      chk("long_cleared", line_err, 0);

      // vsync after 3 rows, then a clean frame
      zero_counts();
      gen_frame(-1, -1, 3, -1, -1, -1, -1);
      idle(3);
      chk("early_writes", wr_cnt, 3 * H);
      zero_counts();
      clean_frame();
      idle(4);
      chk("after_early_writes", wr_cnt, H * V);
      chk("early_frame_err", frame_err, 1);
      chk("after_early_locked", locked, 1);

      // reset at pixel (8,4)
      zero_counts();
      gen_frame(-1, -1, V, -1, -1, 4, 8);
      idle(4);
      chk("rst_mid_writes", wr_cnt, 4 * H + 7);
      chk("rst_mid_flags", {overflow, line_err, frame_err}, 0);
      chk("rst_mid_locked", locked, 0);
      zero_counts();
      clean_frame();
      idle(4);
      chk("after_rst_writes", wr_cnt, H * V);
      chk("after_rst_locked", locked, 1);

      // one frame with capture disabled
      en_base = 1'b0;
      zero_counts();
      clean_frame();
      idle(4);
      chk("en_low_writes", wr_cnt, 0);
      chk("en_low_locked", locked, 0);
      en_base = 1'b1;
      zero_counts();
      clean_frame();
      idle(4);
      chk("en_back_writes", wr_cnt, H * V);
      chk("en_back_locked", locked, 1);

      // randomized frames, checked by the model only
      for (int f = 0; f < 30; f++) begin
         full_pct = $urandom_range(8, 0);
         clr_rate = 10;
         endrop = 1;
         rst_rate = 2;
         gen_frame(($urandom_range(3, 0) == 0) ? int'($urandom_range(V - 1, 0)) : -1,
                   ($urandom_range(3, 0) == 0) ? int'($urandom_range(V - 1, 0)) : -1,
                   ($urandom_range(5, 0) == 0) ? int'($urandom_range(V - 1, 1)) : V,
                   ($urandom_range(3, 0) == 0) ? int'($urandom_range(V - 1, 0)) : -1,
                   int'($urandom_range(H - 1, 0)),
                   ($urandom_range(9, 0) == 0) ? int'($urandom_range(V - 1, 0)) : -1,
                   int'($urandom_range(H - 1, 0)));
         idle(int'($urandom_range(6, 0)));
      end
      full_pct = 0;
      clr_rate = 0;
      endrop = 0;
      rst_rate = 0;
      idle(5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
